uart_tx_param: RTL

Parametrised UART transmitter: configurable data width, parity mode, stop-bit count and baud divisor, with an internal transmit FIFO fronted by a valid/ready write port. It accepts words from the host and serialises them LSB-first on `tx`, back-to-back with no idle gap while the FIFO holds data. It is the next-generation drop-in for the fixed 8N1, single-word transmit path in the UART module.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_param_if.sv | 13 +
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/uart_tx_param.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX paths.
// Holds parity modes, the FSM encoding and the baud divisor helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Rounded to the nearest integer divisor
  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready write port carrying words from the host into the transmitter.
interface uart_tx_param_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; the caller must not push when full.
// Shared between the UART transmit and receive paths.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-fronted, LSB-first, optional parity,
// 1 or 2 stop bits, frames sent back-to-back while the FIFO holds data.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_tx_param_if.slave                wr,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CntW = $clog2(STOP_BITS * DIV);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_param: illegal parameter combination");
  end

  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 push, pop, bit_end;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic [CW-1:0]        count_nxt;

  assign push = wr.tx_valid && ready_q && !fifo_full;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (wr.tx_data),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    bit_end = (baud_q == CntW'(DIV - 1));

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) pop = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BitW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? StParity : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StStop: begin
        if (baud_q == CntW'(STOP_BITS * DIV - 1)) begin
          state_d = StIdle;
          baud_d  = '0;
          if (!fifo_empty) pop = 1'b1;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A pop always starts a fresh frame with a full-length start bit
    if (pop) begin
      state_d = StStart;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = fifo_rdata;
      par_d   = (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
    end

    tx_d = 1'b1;
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    count_nxt = fifo_count + CW'(push) - CW'(pop);
    ready_d   = (count_nxt != CW'(FIFO_DEPTH));
    busy_d    = (state_d != StIdle) || (count_nxt != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign tx          = tx_q;
  assign tx_busy     = busy_q;
  assign wr.tx_ready = ready_q;

endmodule
